timer_arbiter: RTL and testbench

Shares one 8-bit countdown timer between NREQ requesters. Each requester asks for a delay, and a round-robin arbiter grants the timer to one requester at a time. The arbiter loads that requester's delay, counts it down on an external tick strobe, and returns a one-cycle done pulse to the owner. It sits between the tick prescaler and the client blocks, which would otherwise each instantiate a private timer.

---
 rtl/timer_arbiter_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/timer_arbiter.sv | 103 ++++++++++
 tb/tb_timer_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_arbiter_pkg.sv
// Shared types and default sizes for the timer_arbiter block.
package timer_arbiter_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, with wrap.
module rr_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win_onehot,
    output logic [$clog2(NREQ)-1:0] win_idx,
    output logic                    win_any
);

    localparam int IW = $clog2(NREQ);

    int pos;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_any    = 1'b0;
        pos        = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (!win_any && req[pos]) begin
                win_any         = 1'b1;
                win_idx         = pos[IW-1:0];
                win_onehot      = '0;
                win_onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// One shared countdown timer granted round-robin to NREQ requesters.
// Optional build macro TIMER_ARBITER_ABORT_EN: owner dropping req abandons the count.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] delay,
    input  logic              tick,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy
);

    localparam int IW = $clog2(NREQ);

    state_t          state_q, state_nx;
    logic [NREQ-1:0] gnt_q, gnt_nx;
    logic [NREQ-1:0] done_q, done_nx;
    logic [W-1:0]    cnt_q, cnt_nx;
    logic [IW-1:0]   ptr_q, ptr_nx;

    logic [NREQ-1:0] win_onehot;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic            abort;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_any    (win_any)
    );

`ifdef TIMER_ARBITER_ABORT_EN
    assign abort = |(gnt_q & ~req);
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_nx = state_q;
        gnt_nx   = gnt_q;
        done_nx  = '0;
        cnt_nx   = cnt_q;
        ptr_nx   = ptr_q;
        case (state_q)
            IDLE: begin
                // ptr holds the first index to search, i.e. last winner + 1
                if (win_any) begin
                    state_nx = COUNT;
                    gnt_nx   = win_onehot;
                    cnt_nx   = delay[win_idx*W +: W];
                    ptr_nx   = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + IW'(1);
                end
            end
            COUNT: begin
                if (abort) begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                end else if (tick) begin
                    if (cnt_q == '0) begin
                        state_nx = IDLE;
                        gnt_nx   = '0;
                        done_nx  = gnt_q;
                    end else begin
                        cnt_nx = cnt_q - W'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_nx;
            gnt_q   <= gnt_nx;
            done_q  <= done_nx;
            cnt_q   <= cnt_nx;
            ptr_q   <= ptr_nx;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q == COUNT);

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: an event-level model predicts grant/done/release events.
module tb_timer_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] delay;
    logic              tick;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;

    always #5 clk = ~clk;

    timer_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .delay (delay),
        .tick  (tick),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy)
    );

    typedef enum int {EV_GNT, EV_DONE, EV_REL} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       idx;
        int       cyc;
    } ev_t;

    ev_t evq[$];

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    // Reference model: who owns the timer, how many ticks remain until expiry
    int m_owner  = -1;
    int m_ptr    = 0;
    int m_rem    = 0;
    int m_grants = 0;
    int m_dones  = 0;
    bit m_busy   = 1'b0;
    bit mon_en   = 1'b0;

    logic [NREQ-1:0] prev_gnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input ev_kind_t k, input int i);
        ev_t e;
        e.kind = k;
        e.idx  = i;
        e.cyc  = cyc + 1;
        evq.push_back(e);
    endfunction

    function automatic void model_edge(input logic [NREQ-1:0] r, input logic t,
                                       input logic [NREQ*W-1:0] d, input logic rst_v);
        bit ab;
        if (rst_v) begin
            if (m_owner >= 0) push(EV_REL, m_owner);
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int p;
                p = (m_ptr + k) % NREQ;
                if (m_owner < 0 && r[p]) m_owner = p;
            end
            if (m_owner >= 0) begin
                push(EV_GNT, m_owner);
                m_rem = int'(d[m_owner*W +: W]) + 1;
                m_ptr = (m_owner + 1) % NREQ;
                m_grants++;
            end
        end else begin
            ab = 1'b0;
`ifdef TIMER_ARBITER_ABORT_EN
            ab = !r[m_owner];
`endif
            if (ab) begin
                push(EV_REL, m_owner);
                m_owner = -1;
            end else if (t) begin
                m_rem--;
                if (m_rem == 0) begin
                    push(EV_DONE, m_owner);
                    push(EV_REL, m_owner);
                    m_dones++;
                    m_owner = -1;
                end
            end
        end
        m_busy = (m_owner >= 0);
    endfunction

    task automatic drive(input logic [NREQ-1:0] r, input logic t,
                         input logic [NREQ*W-1:0] d, input logic rst_v);
        @(negedge clk);
        req   = r;
        tick  = t;
        delay = d;
        reset = rst_v;
        model_edge(r, t, d, rst_v);
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int n;
        int id;
        n  = 0;
        id = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                n++;
                id = i;
            end
        end
        return (n == 1) ? id : -1;
    endfunction

    task automatic check_ev(input ev_kind_t k, input int idx);
        ev_t e;
        tests++;
        if (evq.size() != 0 && evq[0].cyc == cyc) begin
            e = evq.pop_front();
            if (e.kind != k || e.idx != idx) begin
                fails++;
                $display("FAIL event @%0d: got %s[%0d], required %s[%0d]",
                         cyc, k.name(), idx, e.kind.name(), e.idx);
            end
        end else begin
            fails++;
            $display("FAIL event @%0d: got %s[%0d], required no event", cyc, k.name(), idx);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: turns output changes into events and matches them against the queue
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                while (evq.size() != 0 && evq[0].cyc < cyc) begin
                    e = evq.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL missed %s[%0d]: got nothing by @%0d, required @%0d",
                             e.kind.name(), e.idx, cyc, e.cyc);
                end
                if (done != '0) check_ev(EV_DONE, oh_idx(done));
                if (prev_gnt != '0 && gnt == '0) check_ev(EV_REL, oh_idx(prev_gnt));
                if (prev_gnt == '0 && gnt != '0) check_ev(EV_GNT, oh_idx(gnt));
                if (prev_gnt != '0 && gnt != '0 && gnt != prev_gnt) begin
                    tests++;
                    fails++;
                    $display("FAIL gnt_switch @%0d: got %b, required %b", cyc, gnt, prev_gnt);
                end
                tests++;
                if (busy !== m_busy) begin
                    fails++;
                    $display("FAIL busy @%0d: got %b, required %b", cyc, busy, m_busy);
                end
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ*W-1:0] d;
        logic [NREQ-1:0]   r;
        logic [31:0]       tmp;
        int                start;
        int                gstart;
        ev_t               e;

        req   = '0;
        tick  = 1'b0;
        delay = '0;
        reset = 1'b1;

        drive('0, 1'b1, '0, 1'b1);
        drive('0, 1'b0, '0, 1'b1);
        @(posedge clk);
        #1;
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        mon_en = 1'b1;

        // Single request, delay 3, tick every 4th cycle
        d     = 32'h0000_0003;
        start = m_dones;
        for (int k = 0; k < 60 && m_dones == start; k++) drive(4'b0001, (k % 4) == 3, d, 1'b0);
        for (int k = 0; k < 3; k++) drive('0, 1'b0, d, 1'b0);

        // Zero delay on requester 2
        d     = 32'h0900_0507;
        start = m_dones;
        for (int k = 0; k < 60 && m_dones == start; k++) drive(4'b0100, (k % 3) == 2, d, 1'b0);
        for (int k = 0; k < 2; k++) drive('0, 1'b1, d, 1'b0);

        // Round-robin with every requester pending
        d     = 32'h0101_0101;
        start = m_dones;
        for (int k = 0; k < 100 && m_dones < start + 5; k++) drive(4'b1111, 1'b1, d, 1'b0);
        for (int k = 0; k < 20 && m_owner >= 0; k++) drive('0, 1'b1, d, 1'b0);
        drive('0, 1'b0, d, 1'b0);

        // Full-range delay with the owner's delay scrambled during the count
        start = m_dones;
        for (int k = 0; k < 400 && m_dones == start; k++) begin
            tmp = $urandom();
            d   = tmp;
            if (m_owner < 0) d[7:0] = 8'hFF;
            drive(4'b0001, 1'b1, d, 1'b0);
        end
        drive('0, 1'b0, d, 1'b0);

        // Reset mid-count, then requester 0 must regain top priority
        d = 32'h0000_0409;
        for (int k = 0; k < 5; k++) drive(4'b0001, 1'b1, d, 1'b0);
        drive(4'b0001, 1'b0, d, 1'b1);
        gstart = m_grants;
        for (int k = 0; k < 60 && m_grants < gstart + 2; k++) drive(4'b0011, 1'b1, d, 1'b0);
        for (int k = 0; k < 20 && m_owner >= 0; k++) drive('0, 1'b1, d, 1'b0);

        // Owner drops req mid-count while another requester waits
        d = 32'h0000_1414;
        drive('0, 1'b0, d, 1'b1);
        for (int k = 0; k < 6; k++) drive(4'b0011, (k % 2) == 1, d, 1'b0);
        for (int k = 0; k < 100; k++) drive(4'b0010, (k % 2) == 1, d, 1'b0);
        for (int k = 0; k < 40 && m_owner >= 0; k++) drive('0, 1'b1, d, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            r = 4'($urandom_range(0, 15));
            if (m_owner >= 0) begin
                r[m_owner] = 1'b1;
`ifdef TIMER_ARBITER_ABORT_EN
                if ($urandom_range(0, 15) == 0) r[m_owner] = 1'b0;
`endif
            end
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 19) == 0) d[i*W +: W] = 8'($urandom_range(0, 40));
                else                            d[i*W +: W] = 8'($urandom_range(0, 6));
            end
            drive(r, $urandom_range(0, 1) == 1, d, $urandom_range(0, 499) == 0);
        end

        for (int k = 0; k < 300 && m_owner >= 0; k++) drive('0, 1'b1, d, 1'b0);
        for (int k = 0; k < 3; k++) drive('0, 1'b0, d, 1'b0);
        @(posedge clk);
        #2;
        while (evq.size() != 0) begin
            e = evq.pop_front();
            tests++;
            fails++;
            $display("FAIL leftover %s[%0d]: got nothing, required @%0d", e.kind.name(), e.idx, e.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
